// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED pattern engine.
// Holds the pattern mode encodings and the bounce direction state type used by
// led_pattern_engine. Codes 5-7 carry no name: they all mean "hold the pattern".
package led_ctrl_pkg;

  localparam logic [2:0] ModeRotL   = 3'd0;
  localparam logic [2:0] ModeRotR   = 3'd1;
  localparam logic [2:0] ModeBounce = 3'd2;
  localparam logic [2:0] ModeBar    = 3'd3;
  localparam logic [2:0] ModeBlink  = 3'd4;

  // Direction of the bouncing dot: DirUp walks toward the MSB.
  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Activity-gated prescaler for the LED pattern engine.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset, clears the count
//   active   - count only while high; the count is frozen (not cleared) otherwise
//   clear    - forces the count to zero, overriding active
//   period   - cycles per step minus one
//   terminal - combinational: an active cycle whose count has reached period
module led_tick_gen #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             terminal
);

  logic [CNT_W-1:0] cnt_q;

  // >= rather than == so a period lowered below the running count ends the
  // step on the next active cycle instead of wrapping through 2^CNT_W.
  assign terminal = active && (cnt_q >= period);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (active) begin
      if (terminal) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: steps an LED pattern at a programmable rate while an
// activity level meets a threshold.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   level      - activity count
//   threshold  - minimum level that enables animation
//   period     - clk cycles per pattern step, minus one
//   mode       - pattern select (0 rot-left, 1 rot-right, 2 bounce, 3 bar, 4 blink, 5-7 hold)
//   led        - registered LED drive
//   step_pulse - registered, high for one cycle on each pattern step
module led_pattern_engine
  import led_ctrl_pkg::*;
#(
  parameter int unsigned N_LED = 16,
  parameter int unsigned CNT_W = 24,
  parameter int unsigned LVL_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] level,
  input  logic [LVL_W-1:0] threshold,
  input  logic [CNT_W-1:0] period,
  input  logic [2:0]       mode,
  output logic [N_LED-1:0] led,
  output logic             step_pulse
);

  localparam logic [N_LED-1:0] SeedBit0 = N_LED'(1);

  logic [N_LED-1:0] led_q;
  logic [2:0]       cur_mode_q;
  dir_e             dir_q;
  logic             step_pulse_q;

  logic             active;
  logic             mode_change;
  logic             terminal;
  logic [N_LED-1:0] rot_l;
  logic [N_LED-1:0] rot_r;

  assign active      = (level >= threshold);
  assign mode_change = (mode != cur_mode_q);

  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .clear    (mode_change),
    .period   (period),
    .terminal (terminal)
  );

  // Index-based rotations stay legal for N_LED = 1, where they reduce to identity.
  always_comb begin
    rot_l = '0;
    rot_r = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      rot_l[i] = led_q[(i + N_LED - 1) % N_LED];
      rot_r[i] = led_q[(i + 1) % N_LED];
    end
  end

  // Pattern state and bounce direction FSM. A mode change wins over a
  // coincident step and is applied regardless of activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q        <= SeedBit0;
      cur_mode_q   <= ModeRotL;
      dir_q        <= DirUp;
      step_pulse_q <= 1'b0;
    end else if (mode_change) begin
      cur_mode_q   <= mode;
      led_q        <= (mode == ModeBlink) ? '1 : SeedBit0;
      dir_q        <= DirUp;
      step_pulse_q <= 1'b0;
    end else begin
      step_pulse_q <= terminal;
      if (terminal) begin
        case (cur_mode_q)
          ModeRotL: led_q <= rot_l;
          ModeRotR: led_q <= rot_r;
          ModeBounce: begin
            // A single LED has nowhere to bounce; it just stays lit.
            if (N_LED > 1) begin
              if (dir_q == DirUp) begin
                if (led_q[N_LED-1]) begin
                  led_q <= led_q >> 1;
                  dir_q <= DirDown;
                end else begin
                  led_q <= led_q << 1;
                end
              end else begin
                if (led_q[0]) begin
                  led_q <= led_q << 1;
                  dir_q <= DirUp;
                end else begin
                  led_q <= led_q >> 1;
                end
              end
            end
          end
          ModeBar: begin
            if (&led_q) begin
              led_q <= SeedBit0;
            end else begin
              led_q <= (led_q << 1) | SeedBit0;
            end
          end
          ModeBlink: led_q <= ~led_q;
          default:   led_q <= led_q;
        endcase
      end
    end
  end

  assign led        = led_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 SHALL have parameter N_LED, default 16, meaning LED count, legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default 24, meaning prescaler width.
REQ-003 SHALL have parameter LVL_W, default 7, meaning width of the activity level and threshold.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port level  input  LVL_W  activity count, e.g. cube count.
REQ-007 SHALL have port threshold  input  LVL_W  minimum level that enables animation.
REQ-008 SHALL have port period  input  CNT_W  clk cycles per step, minus one.
REQ-009 SHALL have port mode  input  3  pattern select.
REQ-010 SHALL have port led  output  N_LED  LED drive, registered.
REQ-011 SHALL have port step_pulse  output  1  registered, high for one cycle on each pattern step.

Function
REQ-012 SHALL compute active = (level >= threshold), unsigned, and sample it every cycle.
REQ-013 SHALL, while active, increment the prescaler each cycle; counter >= period = terminal, which clears the counter and fires a step.
REQ-014 SHALL hold the prescaler and led while inactive (freeze, no clear); counting resumes from the held value.
REQ-015 SHALL, with period = 0, step on every active cycle.
REQ-016 SHALL, when period is lowered below the current count, fire a step on the next active cycle (>= compare), never wrapping through 2^CNT_W.
REQ-017 SHALL, on a step, update led and assert step_pulse on the same clock edge (one-cycle latency from terminal count).
REQ-018 SHALL implement mode 0 ROT_L: led <= {led[N-2:0], led[N-1]}.
REQ-019 SHALL implement mode 1 ROT_R: led <= {led[0], led[N-1:1]}.
REQ-020 SHALL implement mode 2 BOUNCE with a dir FSM {UP, DOWN}: UP with led[N-1]=1 shifts right and goes DOWN, else shifts left; DOWN with led[0]=1 shifts left and goes UP, else shifts right.
REQ-021 SHALL implement mode 3 BAR: led <= {led[N-2:0],1'b1}; when led is all-ones, next step loads bit0 only.
REQ-022 SHALL implement mode 4 BLINK: led <= ~led.
REQ-023 SHALL treat modes 5-7 as HOLD: led unchanged; prescaler and step_pulse run normally.
REQ-024 SHALL register mode into cur_mode; when mode != cur_mode, the next edge loads the seed for the new mode, clears the prescaler, sets dir=UP, and suppresses step_pulse.
REQ-025 SHALL use seed bit0 only (...0001) for modes 0-3 and 5-7, and all-ones for mode 4.
REQ-026 SHALL give a mode change priority over a coincident step; the mode change is applied even while inactive.
REQ-027 SHALL, for N_LED = 1, keep led = 1 in modes 0-3 and toggle it in BLINK.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, set led=...0001, prescaler=0, cur_mode=0, dir=UP, step_pulse=0; rst overrides all other inputs including a mid-count or mid-bounce state.
REQ-029 SHALL make the first step after reset release occur period+1 active cycles later.

Structure
REQ-030 SHALL place the mode encodings (ROT_L, ROT_R, BOUNCE, BAR, BLINK) and the dir FSM state type in shared package led_ctrl_pkg.
REQ-031 SHALL implement the prescaler (active gating, >= terminal, clear input) as sub-module led_tick_gen; pattern logic and FSM stay in the top level.

Verification
REQ-032 SHALL test: N_LED=16, mode 0, period=3, level=20, threshold=16 -> led steps 0x0001 -> 0x0002 every 4 cycles, wrapping 0x8000 -> 0x0001 after 16 steps, with step_pulse high once per step.
REQ-033 SHALL test: mode 2, period=0 -> led walks bit0..bit15 then bit14..bit0, with dir flipping exactly at bit15 and bit0, for a 30-step cycle.
REQ-034 SHALL test: level drops 20 -> 10 mid-count at count 2 of period 5 -> led and counter frozen; on restore to 20 the step fires after 3 further cycles.
REQ-035 SHALL test: mode switches 0 -> 4 on the terminal-count cycle -> next led = 0xFFFF, step_pulse=0, and the following steps give 0x0000 and then 0xFFFF.
REQ-036 SHALL test: mode 3, period=1 -> led 0x0001, 0x0003 ... 0xFFFF, then 0x0001.
REQ-037 SHALL test: rst asserted mid-bounce -> next cycle led=0x0001, step_pulse=0, dir=UP.
